shl_seq: RTL and testbench



---
 rtl/shl_seq.sv | 117 +++++++++++
 tb/tb_shl_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// shl_seq: multi-cycle 32-bit logical left shifter.
// The shift amount is applied as five fixed stages of 16, 8, 4, 2 and 1 bits,
// one stage per clock. Every operation therefore takes the same number of
// cycles, whatever the amount. The result is published on d_out together with
// a one-cycle done pulse.
module shl_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  sh_amt,
  input  logic [31:0] d_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] d_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] work;
  logic [4:0]  amt;
  logic [2:0]  stage;
  logic        accept;
  logic [31:0] work_shifted;

  // Stage 0..4 applies a 16/8/4/2/1-bit shift when amount bit 4..0 is set.
  // Zeros fill the low end and bits shifted past bit 31 are dropped.
  function automatic logic [31:0] stage_shift(input logic [31:0] w,
                                              input logic [4:0]  a,
                                              input logic [2:0]  s);
    logic [31:0] r;
    r = w;
    case (s)
      3'd0:    if (a[4]) r = {w[15:0], 16'h0000};
      3'd1:    if (a[3]) r = {w[23:0], 8'h00};
      3'd2:    if (a[2]) r = {w[27:0], 4'h0};
      3'd3:    if (a[1]) r = {w[29:0], 2'b00};
      3'd4:    if (a[0]) r = {w[30:0], 1'b0};
      default: r = w;
    endcase
    return r;
  endfunction

  assign work_shifted = stage_shift(work, amt, stage);

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and status outputs. start is honoured only when not busy.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (stage == LAST_STAGE) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture the operands on accept, run one stage per clock in
  // SHIFT, and publish the result only when the last stage completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= 32'h0;
      amt   <= 5'h0;
      stage <= 3'h0;
      d_out <= 32'h0;
    end else if (accept) begin
      work  <= d_in;
      amt   <= sh_amt;
      stage <= 3'h0;
    end else if (state == SHIFT) begin
      work  <= work_shifted;
      stage <= stage + 3'd1;
      if (stage == LAST_STAGE) begin
        d_out <= work_shifted;
      end
    end
  end

endmodule

// File: tb/tb_shl_seq.sv
// tb_shl_seq: testbench for shl_seq. A cycle-level behavioural model tracks
// the operation phase and the expected result, computed with a plain <<.
// A compare process checks the DUT against the model on every falling edge.
// Directed scenarios also pin hand-computed literal values.
module tb_shl_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  sh_amt;
  logic [31:0] d_in;
  logic        busy;
  logic        done;
  logic [31:0] d_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: ph 0 = idle, 1..5 = busy cycles, 6 = result cycle.
  int          ph;
  logic [31:0] m_res;
  logic [31:0] m_dout;

  shl_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sh_amt (sh_amt),
    .d_in   (d_in),
    .busy   (busy),
    .done   (done),
    .d_out  (d_out)
  );

  initial clk = 1'b0;
  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fixed 5-cycle busy window, then one result cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     = 0;
      m_res  = 32'h0;
      m_dout = 32'h0;
    end else begin
      if ((ph == 0 || ph == 6) && start) begin
        ph    = 1;
        m_res = d_in << sh_amt;
      end else if (ph == 5) begin
        ph     = 6;
        m_dout = m_res;
      end else if (ph == 6) begin
        ph = 0;
      end else if (ph != 0) begin
        ph = ph + 1;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_busy", {31'h0, busy}, {31'h0, (ph >= 1 && ph <= 5)});
      check("model_done", {31'h0, done}, {31'h0, (ph == 6)});
      check("model_dout", d_out, m_dout);
    end
  end

  // Single operation from idle, with literal expected result and latency.
  task automatic do_op(input logic [31:0] d, input logic [4:0] a,
                       input logic [31:0] exp, input string name);
    int k;
    @(negedge clk);
    start  = 1'b1;
    d_in   = d;
    sh_amt = a;
    @(negedge clk);
    start  = 1'b0;
    d_in   = $urandom;
    sh_amt = 5'($urandom);
    check({name, "_busy_start"}, {31'h0, busy}, 32'h1);
    k = 1;
    while (!done && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k - 1, 32'd5);
    check({name, "_dout"}, d_out, exp);
    check({name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    check({name, "_dout_hold"}, d_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int ndone;
    logic [31:0] rd;
    rst_n  = 1'b0;
    start  = 1'b0;
    d_in   = 32'h0;
    sh_amt = 5'h0;
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_dout", d_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Basic and boundary operations with literal results.
    do_op(32'h0000_00F1, 5'd4,  32'h0000_0F10, "basic");
    do_op(32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, "amt0");
    do_op(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, "amt31");
    do_op(32'h8000_0001, 5'd1,  32'h0000_0002, "msb_drop");

    // START while busy is ignored; late operand changes do not leak in.
    @(negedge clk);
    start = 1'b1; d_in = 32'h1; sh_amt = 5'd3;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) begin
        d_in = 32'h1234_5678; sh_amt = 5'd8;
      end
      if (done) ndone++;
      if (i == 6) begin
        check("ignored_done_t5", {31'h0, done}, 32'h1);
        check("ignored_dout", d_out, 32'h0000_0008);
      end
    end
    check("ignored_single_done", ndone, 32'd1);

    // Back-to-back with START held high.
    @(negedge clk);
    start = 1'b1; d_in = 32'hA5A5_A5A5; sh_amt = 5'd8;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        d_in = 32'h0000_FFFF; sh_amt = 5'd16;
      end
      if (i == 7) start = 1'b0;
      if (i == 6) begin
        check("b2b_done1", {31'h0, done}, 32'h1);
        check("b2b_dout1", d_out, 32'hA5A5_A500);
      end else if (i >= 7 && i <= 11) begin
        check("b2b_done_gap", {31'h0, done}, 32'h0);
        check("b2b_dout_stable", d_out, 32'hA5A5_A500);
      end else if (i == 12) begin
        check("b2b_done2", {31'h0, done}, 32'h1);
        check("b2b_dout2", d_out, 32'hFFFF_0000);
      end
    end

    // Every shift amount with a random operand.
    for (int a = 0; a < 32; a++) begin
      rd = $urandom;
      do_op(rd, 5'(a), rd << a, "sweep");
    end

    // Random traffic; the compare process checks each cycle.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start  = 1'($urandom);
      d_in   = $urandom;
      sh_amt = 5'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; d_in = 32'hDEAD_BEEF; sh_amt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midreset_busy_before", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_done", {31'h0, done}, 32'h0);
    check("midreset_dout", d_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
      check("postreset_dout", d_out, 32'h0);
    end
    check("postreset_no_done", ndone, 32'd0);

    // First START after reset release is taken on the first rising edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; d_in = 32'h0000_0003; sh_amt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    check("release_accept_busy", {31'h0, busy}, 32'h1);
    repeat (6) @(negedge clk);
    check("release_dout", d_out, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
